prv32_sim_memsys: RTL and testbench
===================================

Name: prv32_sim_memsys

Overview:
Parametrised, synthesizable memory/peripheral responder for the picorv32 native memory interface. It is the next generation of the bench memory model, console and IRQ generator, packaged as one reusable block. It provides:
- word RAM with configurable wait states and optional jitter;
- memory-mapped console TX FIFO with a stream output and backpressure;
- N programmable periodic IRQ timers;
- console-activity watchdog.
Sits between the picorv32 core and the testbench/FPGA top.

Parameters:
MEM_WORDS, 16384, RAM depth in 32-bit words (power of two)
MEM_LATENCY, 1, base cycles from accepted request to mem_ready (>=1)
LAT_JITTER, 0, 1 = add 0..3 extra wait cycles from a free-running 16-bit LFSR
INIT_FILE, "firmware.hex", $readmemh image; empty string = no preload
CON_ADDR, 32'h1000_0000, console data/status register
TMR_BASE, 32'h1000_0100, timer i reload register at TMR_BASE+4*i
NUM_TIMERS, 2, timer channels (1..8); timer i drives irq[4+i]
CON_DEPTH, 16, console FIFO depth (power of two, >=2)
WDT_LIMIT, 10000, idle cycles without a console write before wdt_expired

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
mem_valid  in  1  core request valid
mem_instr  in  1  instruction fetch (informational only)
mem_ready  out  1  one-cycle completion pulse
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte strobes; 0 = read
mem_rdata  out  32  read data, valid with mem_ready
irq  out  32  interrupt lines; only irq[4+i] are used, all other bits 0
con_valid  out  1  console byte available
con_ready  in  1  sink accepts byte
con_data  out  8  console byte
wdt_expired  out  1  sticky watchdog flag
bus_err  out  1  one-cycle pulse on an unmapped access

Behaviour:
- Reset: async assert while resetn=0. Effects:
  - all outputs 0; FSM returns to IDLE; FIFO emptied; timer reloads and counters 0; watchdog count 0; LFSR reset to 16'hACE1.
  - RAM contents are not reset.
  - Reset mid-transaction drops the pending request; no mem_ready is issued for it.
- FSM states: IDLE, WAIT, RESP.
  - IDLE & mem_valid: latch address, data and strobes; load wait counter = MEM_LATENCY-1 (+ LFSR[1:0] if LAT_JITTER); go to WAIT, or directly to RESP when the wait count is 0.
  - WAIT: decrement the counter each cycle; at 0 go to RESP.
  - RESP: perform the access, pulse mem_ready for one cycle, return to IDLE.
  - With MEM_LATENCY=1 and no jitter, mem_ready is high in the 2nd cycle after mem_valid is sampled.
  - The next request is accepted no earlier than the cycle after the mem_ready pulse.
- RAM: index = addr[2+:log2(MEM_WORDS)], used when addr < 4*MEM_WORDS.
  - mem_rdata returns the old word (read-before-write).
  - Bytes are written per strobe.
- Console write (CON_ADDR, any strobe): push wdata[7:0].
  - If the FIFO is full, RESP stalls (mem_ready held low) until a pop frees a slot.
  - A push and pop in the same cycle while full is allowed and completes.
- Console read: rdata = {23'b0, full, 8'(count)}; no pop.
- con_valid = !empty; con_data = head; pop on con_valid & con_ready.
- Timers:
  - Write reload R: counter <= R. Read returns reload.
  - R=0 disables the channel.
  - Otherwise the counter decrements each cycle. On reaching 1, irq[4+i] pulses for 1 cycle and the counter reloads R, giving a period of exactly R cycles.
  - A write coinciding with expiry: the write wins and no pulse is generated.
- Unmapped address: rdata 0, writes dropped, mem_ready still pulses, bus_err pulses in the same cycle.
- Watchdog:
  - Counter increments each cycle and clears on an accepted console push.
  - When it reaches WDT_LIMIT, wdt_expired=1 and stays set until reset; the counter saturates.

Decomposition:
- Package prv32_sim_pkg:
  - FSM state enum;
  - address-map constants and a decode function (region enum: RAM, CON, TMR, NONE);
  - LFSR polynomial constant (x^16+x^14+x^13+x^11+1).
- Sub-module prv32_con_fifo:
  - parametrised sync FIFO with push/pop/full/empty/count;
  - same clk/resetn style.

Test Plan:
- Preload word 0x10 = 32'hDEADBEEF; read 0x40 at MEM_LATENCY=3 -> mem_ready exactly 4 cycles after mem_valid, rdata=32'hDEADBEEF.
- Write 0x40, wstrb=4'b0010, wdata=32'h0000_5500, then read -> 32'hDEAD55EF.
- CON_DEPTH=4, con_ready=0, 5 console writes -> 5th write's mem_ready withheld; single pop -> 5th completes; drain order matches write order.
- Timer0 reload=100 -> irq[4] pulses every 100 cycles exactly; write 0 -> no further pulses; irq[31:6] stays 0.
- Read 0x2000_0000 -> rdata 0, bus_err and mem_ready pulse in the same cycle.
- WDT_LIMIT=50 with no console writes -> wdt_expired=1 at count 50 and stays set; resetn pulse mid-WAIT -> all outputs 0, no stray mem_ready.

Source files
------------

// File: rtl/prv32_sim_pkg.sv
// Shared types, address-map defaults and helpers for the picorv32 simulation memory system.
package prv32_sim_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  typedef enum logic [1:0] {REG_RAM, REG_CON, REG_TMR, REG_NONE} region_e;

  localparam logic [31:0] DEF_CON_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEF_TMR_BASE = 32'h1000_0100;

  // Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_POLY : 16'h0000);
  endfunction

  function automatic region_e decode_addr(input logic [31:0] addr,
                                          input logic [31:0] ram_bytes,
                                          input logic [31:0] con_addr,
                                          input logic [31:0] tmr_base,
                                          input logic [31:0] tmr_bytes);
    if (addr < ram_bytes)                                   return REG_RAM;
    if (addr[31:2] == con_addr[31:2])                       return REG_CON;
    if (addr >= tmr_base && addr < tmr_base + tmr_bytes)    return REG_TMR;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/prv32_con_fifo.sv
// Synchronous console FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module prv32_con_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/prv32_sim_memsys.sv
// picorv32 native-bus responder: wait-stated RAM, console FIFO, periodic IRQ timers and console watchdog.
module prv32_sim_memsys
  import prv32_sim_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 16384,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned LAT_JITTER  = 0,
  parameter string       INIT_FILE   = "firmware.hex",
  parameter logic [31:0] CON_ADDR    = DEF_CON_ADDR,
  parameter logic [31:0] TMR_BASE    = DEF_TMR_BASE,
  parameter int unsigned NUM_TIMERS  = 2,
  parameter int unsigned CON_DEPTH   = 16,
  parameter int unsigned WDT_LIMIT   = 10000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic [31:0] irq,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [7:0]  con_data,
  output logic        wdt_expired,
  output logic        bus_err
);

  localparam int unsigned MW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(CON_DEPTH) + 1;

  state_e          state, state_nx;
  logic [15:0]     wait_cnt, wait_load, lfsr;
  logic [31:0]     req_addr, req_wdata, rdata_mux, wdt_cnt;
  logic [3:0]      req_wstrb;
  region_e         req_region;
  logic            req_wr, accept, resp_do, con_stall;
  logic [MW-1:0]   ram_idx;
  logic [31:0]     ram [MEM_WORDS];

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_head;
  logic [CW-1:0]   fifo_count;

  logic [31:0]           tmr_reload [NUM_TIMERS];
  logic [31:0]           tmr_cnt    [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] tmr_wr, irq_r;
  logic [31:0]           tmr_rdata;

  logic unused_instr;
  assign unused_instr = mem_instr;

  assign req_wr     = |req_wstrb;
  assign req_region = decode_addr(req_addr, 32'(4 * MEM_WORDS), CON_ADDR, TMR_BASE,
                                  32'(4 * NUM_TIMERS));
  assign ram_idx    = req_addr[2 +: MW];
  // mem_ready is still high in the cycle the core withdraws mem_valid, so block re-acceptance then
  assign accept     = (state == ST_IDLE) && mem_valid && !mem_ready;
  assign wait_load  = 16'(MEM_LATENCY - 1) + ((LAT_JITTER != 0) ? {14'd0, lfsr[1:0]} : 16'd0);
  assign fifo_pop   = !fifo_empty && con_ready;
  assign con_stall  = (state == ST_RESP) && (req_region == REG_CON) && req_wr
                      && fifo_full && !fifo_pop;
  assign resp_do    = (state == ST_RESP) && !con_stall;
  assign fifo_push  = resp_do && (req_region == REG_CON) && req_wr;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept) state_nx = (wait_load == '0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt == 16'd1) state_nx = ST_RESP;
      ST_RESP: if (!con_stall) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    tmr_wr    = '0;
    tmr_rdata = '0;
    for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
      if ({req_addr[31:2], 2'b00} == TMR_BASE + 32'(4 * i)) begin
        tmr_wr[i] = resp_do && (req_region == REG_TMR) && req_wr;
        tmr_rdata = tmr_reload[i];
      end
    end
  end

  always_comb begin
    rdata_mux = '0;
    unique case (req_region)
      REG_RAM: rdata_mux = ram[ram_idx];
      REG_CON: rdata_mux = {23'd0, fifo_full, 8'(fifo_count)};
      REG_TMR: rdata_mux = tmr_rdata;
      default: rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr      <= LFSR_SEED;
      wait_cnt  <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      lfsr      <= lfsr_next(lfsr);
      mem_ready <= resp_do;
      bus_err   <= resp_do && (req_region == REG_NONE);
      if (accept) begin
        req_addr  <= mem_addr;
        req_wdata <= mem_wdata;
        req_wstrb <= mem_wstrb;
        wait_cnt  <= wait_load;
      end else if (state == ST_WAIT) begin
        wait_cnt  <= wait_cnt - 16'd1;
      end
      if (resp_do) mem_rdata <= rdata_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (resp_do && (req_region == REG_RAM)) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (req_wstrb[b]) ram[ram_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // A reload write takes priority over a coinciding expiry and suppresses that pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_r <= '0;
      for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
        tmr_reload[i] <= '0;
        tmr_cnt[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
        if (tmr_wr[i]) begin
          tmr_reload[i] <= req_wdata;
          tmr_cnt[i]    <= req_wdata;
          irq_r[i]      <= 1'b0;
        end else if (tmr_reload[i] == '0) begin
          irq_r[i]      <= 1'b0;
        end else if (tmr_cnt[i] == 32'd1) begin
          irq_r[i]      <= 1'b1;
          tmr_cnt[i]    <= tmr_reload[i];
        end else begin
          irq_r[i]      <= 1'b0;
          tmr_cnt[i]    <= tmr_cnt[i] - 32'd1;
        end
      end
    end
  end

  assign irq = 32'({irq_r, 4'b0000});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdt_cnt     <= '0;
      wdt_expired <= 1'b0;
    end else begin
      if (fifo_push)                    wdt_cnt <= '0;
      else if (wdt_cnt != WDT_LIMIT)    wdt_cnt <= wdt_cnt + 32'd1;
      if (!fifo_push && (wdt_cnt == WDT_LIMIT - 1)) wdt_expired <= 1'b1;
    end
  end

  prv32_con_fifo #(
    .DEPTH (CON_DEPTH),
    .WIDTH (8)
  ) u_con_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .wdata  (req_wdata[7:0]),
    .pop    (fifo_pop),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign con_valid = !fifo_empty;
  assign con_data  = fifo_empty ? 8'h00 : fifo_head;

endmodule

// File: tb/tb_prv32_sim_memsys.sv
// Directed scoreboard bench for prv32_sim_memsys (latency 3, 4-deep console FIFO, watchdog limit 50).
module tb_prv32_sim_memsys;

  localparam logic [31:0] CON_A = 32'h1000_0000;
  localparam logic [31:0] TMR_A = 32'h1000_0100;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        mem_valid = 1'b0, mem_instr = 1'b0, con_ready = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready, con_valid, wdt_expired, bus_err;
  logic [31:0] mem_rdata, irq;
  logic [7:0]  con_data;

  int n_cmp = 0, n_err = 0, cyc = 0, ready_cyc = 0;

  typedef struct {logic [31:0] rd; logic err; logic chk_rd;} exp_t;
  exp_t       sb[$];
  logic [7:0] conq[$];

  prv32_sim_memsys #(
    .MEM_WORDS   (1024),
    .MEM_LATENCY (3),
    .LAT_JITTER  (0),
    .INIT_FILE   (""),
    .CON_ADDR    (CON_A),
    .TMR_BASE    (TMR_A),
    .NUM_TIMERS  (2),
    .CON_DEPTH   (4),
    .WDT_LIMIT   (50)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .mem_valid   (mem_valid),
    .mem_instr   (mem_instr),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .irq         (irq),
    .con_valid   (con_valid),
    .con_ready   (con_ready),
    .con_data    (con_data),
    .wdt_expired (wdt_expired),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] want_rd, input logic want_err,
                      input logic chk_rd, input int want_lat);
    exp_t e;
    int   lat;
    logic done;
    sb.push_back('{want_rd, want_err, chk_rd});
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    lat = 0; done = 1'b0;
    while (!done && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (mem_ready === 1'b1) done = 1'b1;
    end
    e = sb.pop_front();
    chk({tag, "_ready"}, 32'(done), 32'd1);
    if (done) begin
      chk({tag, "_lat"}, lat, want_lat);
      if (e.chk_rd) chk({tag, "_rdata"}, mem_rdata, e.rd);
      chk({tag, "_buserr"}, 32'(bus_err), 32'(e.err));
      ready_cyc = cyc;
    end
    mem_valid = 1'b0; mem_wstrb = '0;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(mem_ready), 32'd0);
  endtask

  initial begin
    int        stray, other, n4, n5, drained;
    int        p[$];
    logic [7:0] b;

    // reset
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq", irq, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_ctl", 32'({con_data, mem_ready, bus_err, con_valid, wdt_expired}), 32'd0);
    @(negedge clk) resetn = 1'b1;

    // watchdog with no console traffic
    repeat (49) @(posedge clk);
    #1 chk("wdt_at_49", 32'(wdt_expired), 32'd0);
    @(posedge clk); #1 chk("wdt_at_50", 32'(wdt_expired), 32'd1);
    repeat (20) @(posedge clk);
    #1 chk("wdt_held", 32'(wdt_expired), 32'd1);

    // RAM: full write, read, byte-strobe write (read-before-write), read
    xfer("ram_wr_full", 32'h40, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0, 4);
    xfer("ram_rd", 32'h40, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 4);
    xfer("ram_wr_byte1", 32'h40, 32'h0000_5500, 4'b0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 4);
    xfer("ram_rd_merged", 32'h40, 32'h0, 4'h0, 32'hDEAD_55EF, 1'b0, 1'b1, 4);
    xfer("ram_wr_last", 32'hFFC, 32'h1234_AA55, 4'hF, 32'h0, 1'b0, 1'b0, 4);
    xfer("ram_rd_last", 32'hFFC, 32'h0, 4'h0, 32'h1234_AA55, 1'b0, 1'b1, 4);

    // unmapped accesses
    xfer("unmapped_rd", 32'h2000_0000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 4);
    xfer("ram_end_rd", 32'h0000_1000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 4);
    xfer("tmr_end_wr", TMR_A + 32'd8, 32'h5, 4'hF, 32'h0, 1'b1, 1'b1, 4);

    // timer 0 period 100
    xfer("tmr0_wr", TMR_A, 32'd100, 4'hF, 32'h0, 1'b0, 1'b0, 4);
    other = 0;
    for (int k = 0; k < 250; k++) begin
      if (irq[4] === 1'b1) p.push_back(cyc - ready_cyc);
      other |= int'(irq & ~32'h10);
      @(posedge clk); #1;
    end
    chk("tmr0_npulses", p.size(), 2);
    chk("tmr0_first", (p.size() > 0) ? p[0] : -1, 100);
    chk("tmr0_second", (p.size() > 1) ? p[1] : -1, 200);
    chk("irq_other_bits", other, 0);
    xfer("tmr0_rd", TMR_A, 32'h0, 4'h0, 32'd100, 1'b0, 1'b1, 4);
    xfer("tmr1_rd", TMR_A + 32'd4, 32'h0, 4'h0, 32'd0, 1'b0, 1'b1, 4);

    // timer 1 period 3, then disable
    xfer("tmr1_wr", TMR_A + 32'd4, 32'd3, 4'hF, 32'h0, 1'b0, 1'b0, 4);
    n5 = 0;
    for (int k = 0; k < 30; k++) begin
      if (irq[5] === 1'b1) n5++;
      @(posedge clk); #1;
    end
    chk("tmr1_npulses", n5, 10);
    xfer("tmr1_off", TMR_A + 32'd4, 32'd0, 4'hF, 32'h0, 1'b0, 1'b0, 4);
    xfer("tmr0_off", TMR_A, 32'd0, 4'hF, 32'h0, 1'b0, 1'b0, 4);
    n4 = 0; n5 = 0;
    for (int k = 0; k < 250; k++) begin
      if (irq[4] === 1'b1) n4++;
      if (irq[5] === 1'b1) n5++;
      @(posedge clk); #1;
    end
    chk("tmr_disabled", n4 + n5, 0);

    // console: fill, stall, single pop, drain
    xfer("con_stat_empty", CON_A, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 4);
    for (int i = 0; i < 4; i++) begin
      b = 8'hA0 + 8'(i);
      conq.push_back(b);
      xfer("con_wr", CON_A, {24'h5A5A5A, b}, 4'b0001, 32'h0, 1'b0, 1'b0, 4);
    end
    xfer("con_stat_full", CON_A, 32'h0, 4'h0, 32'h0000_0104, 1'b0, 1'b1, 4);
    chk("wdt_sticky", 32'(wdt_expired), 32'd1);

    @(negedge clk);
    mem_valid = 1'b1; mem_addr = CON_A; mem_wdata = 32'h0000_00A4; mem_wstrb = 4'b0001;
    conq.push_back(8'hA4);
    stray = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) stray++;
    end
    chk("con_stall", stray, 0);
    chk("con_valid_full", 32'(con_valid), 32'd1);
    con_ready = 1'b1;
    b = conq.pop_front();
    chk("con_pop0", 32'(con_data), 32'(b));
    @(posedge clk); #1;
    con_ready = 1'b0;
    chk("con_unstall", 32'(mem_ready), 32'd1);
    mem_valid = 1'b0; mem_wstrb = '0;
    @(posedge clk); #1;

    con_ready = 1'b1;
    drained = 0;
    for (int g = 0; g < 20 && con_valid === 1'b1; g++) begin
      if (conq.size() > 0) begin
        b = conq.pop_front();
        chk("con_drain", 32'(con_data), 32'(b));
      end else begin
        chk("con_extra", 32'(con_valid), 32'd0);
      end
      drained++;
      @(posedge clk); #1;
    end
    con_ready = 1'b0;
    chk("con_drain_cnt", drained, 4);
    chk("con_empty", 32'(con_valid), 32'd0);

    // reset while in WAIT
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h40; mem_wstrb = 4'h0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("rstw_irq", irq, 32'd0);
    chk("rstw_rdata", mem_rdata, 32'd0);
    chk("rstw_ctl", 32'({con_data, mem_ready, bus_err, con_valid, wdt_expired}), 32'd0);
    mem_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    stray = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) stray++;
    end
    chk("rstw_no_ready", stray, 0);
    xfer("ram_kept", 32'h40, 32'h0, 4'h0, 32'hDEAD_55EF, 1'b0, 1'b1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
